// File: rtl/zkbd_pkg.sv
// zkbd_pkg: shared defaults and mouse-port select encodings for zkbdmus_gen.
//   NCOLS_DEF/NJOY_DEF/KJW_DEF/STICKY_DEF - parameter defaults
//   msel_e / msel_decode                  - which mouse register zah selects
package zkbd_pkg;
  localparam int NCOLS_DEF  = 5;
  localparam int NJOY_DEF   = 1;
  localparam int KJW_DEF    = 5;
  localparam bit STICKY_DEF = 1'b1;

  localparam logic [2:0] MUSBTN_RST = 3'b111;

  typedef enum logic [1:0] {
    MSEL_BTN = 2'd0,  // {wheel, 1, buttons}
    MSEL_X   = 2'd1,
    MSEL_Y   = 2'd2
  } msel_e;

  // zah[0]=0 -> buttons/wheel; else zah[2] picks X (0) or Y (1).
  function automatic msel_e msel_decode(input logic z0, input logic z2);
    if (!z0)      return MSEL_BTN;
    else if (!z2) return MSEL_X;
    else          return MSEL_Y;
  endfunction
endpackage

// File: rtl/zmus_acc.sv
// zmus_acc: W-bit load/accumulate register.
//   i_clk, i_rst_n : clock, async active-low reset (clears to 0)
//   i_stb          : update strobe
//   i_rel          : 0 = load i_din, 1 = add i_din modulo 2^W
//   i_din / o_q    : data in / register value
module zmus_acc #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_stb,
  input  logic         i_rel,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_q <= '0;
    else if (i_stb) r_q <= i_rel ? (r_q + i_din) : i_din;
  end

  assign o_q = r_q;
endmodule

// File: rtl/zkbdmus_gen.sv
// zkbdmus_gen: keyboard matrix / mouse / joystick port generator.
//   fclk, rst_n            : clock, async active-low reset
//   kbd_in/_sel/_stb       : write one column byte into the shadow frame
//   kbd_commit             : publish shadow frame to the live matrix
//   kbd_rd                 : keyboard port read; clears sticky rows selected by zah
//   mus_*                  : mouse X/Y/buttons/wheel loads (absolute or relative)
//   kj_stb, kj_sel         : joystick channel load from mus_in
//   zah                    : Z80 address high byte (active-low row select)
//   kbd_data, mus_data     : combinational port data
//   kj_data                : joystick channels, channel n at [n*KJW +: KJW]
module zkbdmus_gen
  import zkbd_pkg::*;
#(
  parameter int NCOLS  = NCOLS_DEF,
  parameter int NJOY   = NJOY_DEF,
  parameter int KJW    = KJW_DEF,
  parameter bit STICKY = STICKY_DEF
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  input  logic [7:0]           kbd_in,
  input  logic [2:0]           kbd_in_sel,
  input  logic                 kbd_stb,
  input  logic                 kbd_commit,
  input  logic                 kbd_rd,
  input  logic [7:0]           mus_in,
  input  logic                 mus_xstb,
  input  logic                 mus_ystb,
  input  logic                 mus_btnstb,
  input  logic                 mus_rel,
  input  logic                 kj_stb,
  input  logic [1:0]           kj_sel,
  input  logic [7:0]           zah,
  output logic [NCOLS-1:0]     kbd_data,
  output logic [7:0]           mus_data,
  output logic [NJOY*KJW-1:0]  kj_data
);

  // ---------------- keyboard ----------------
  // Byte b holds rows 0..7 of output column NCOLS-1-b. Selects >= NCOLS
  // match no byte and are dropped naturally.
  for (genvar b = 0; b < NCOLS; b++) begin : g_col
    logic [7:0] r_shadow, r_live;
    logic [7:0] w_shadow_nxt, w_eff;

    // Commit in the same cycle as a write sees the new byte.
    assign w_shadow_nxt = (kbd_stb && kbd_in_sel == 3'(b)) ? kbd_in : r_shadow;

    always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_live   <= '0;
      end else begin
        r_shadow <= w_shadow_nxt;
        if (kbd_commit) r_live <= w_shadow_nxt;
      end
    end

    if (STICKY) begin : g_sticky
      logic [7:0] r_sticky, w_set, w_clr;
      assign w_set = kbd_commit ? w_shadow_nxt : 8'h00;
      assign w_clr = kbd_rd ? ~zah : 8'h00;
      // Set beats clear so a press landing on a read is not lost.
      always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) r_sticky <= '0;
        else        r_sticky <= (r_sticky & ~w_clr) | w_set;
      end
      assign w_eff = r_live | r_sticky;
    end else begin : g_plain
      assign w_eff = r_live;
    end

    // Column low if any selected row (zah bit 0) has the key pressed.
    assign kbd_data[NCOLS-1-b] = &(zah | ~w_eff);
  end

  // ---------------- mouse ----------------
  logic [7:0] w_musx, w_musy;
  logic [3:0] w_wheel;
  logic [2:0] r_musbtn;

  zmus_acc #(.W(8)) u_musx (
    .i_clk(fclk), .i_rst_n(rst_n), .i_stb(mus_xstb), .i_rel(mus_rel),
    .i_din(mus_in), .o_q(w_musx)
  );

  zmus_acc #(.W(8)) u_musy (
    .i_clk(fclk), .i_rst_n(rst_n), .i_stb(mus_ystb), .i_rel(mus_rel),
    .i_din(mus_in), .o_q(w_musy)
  );

  zmus_acc #(.W(4)) u_wheel (
    .i_clk(fclk), .i_rst_n(rst_n), .i_stb(mus_btnstb), .i_rel(mus_rel),
    .i_din(mus_in[7:4]), .o_q(w_wheel)
  );

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n)          r_musbtn <= MUSBTN_RST;
    else if (mus_btnstb) r_musbtn <= mus_in[2:0];
  end

  always_comb begin
    case (msel_decode(zah[0], zah[2]))
      MSEL_BTN: mus_data = {w_wheel, 1'b1, r_musbtn};
      MSEL_X:   mus_data = w_musx;
      default:  mus_data = w_musy;
    endcase
  end

  // ---------------- joystick ----------------
  for (genvar n = 0; n < NJOY; n++) begin : g_kj
    logic [KJW-1:0] r_ch;
    always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)                          r_ch <= '0;
      else if (kj_stb && kj_sel == 2'(n))  r_ch <= mus_in[KJW-1:0];
    end
    assign kj_data[n*KJW +: KJW] = r_ch;
  end

endmodule

// File: tb/tb_zkbdmus_gen.sv
module tb_zkbdmus_gen;
  localparam int NC = 5;
  localparam int NJ = 2;
  localparam int KW = 5;

  logic fclk = 1'b0;
  logic rst_n;
  logic [7:0] kbd_in;
  logic [2:0] kbd_in_sel;
  logic kbd_stb, kbd_commit, kbd_rd;
  logic [7:0] mus_in;
  logic mus_xstb, mus_ystb, mus_btnstb, mus_rel;
  logic kj_stb;
  logic [1:0] kj_sel;
  logic [7:0] zah;
  logic [NC-1:0] kbd_data;
  logic [7:0] mus_data;
  logic [NJ*KW-1:0] kj_data;

  always #5 fclk = ~fclk;

  zkbdmus_gen #(.NCOLS(NC), .NJOY(NJ), .KJW(KW), .STICKY(1'b1)) dut (
    .fclk(fclk), .rst_n(rst_n), .kbd_in(kbd_in), .kbd_in_sel(kbd_in_sel),
    .kbd_stb(kbd_stb), .kbd_commit(kbd_commit), .kbd_rd(kbd_rd),
    .mus_in(mus_in), .mus_xstb(mus_xstb), .mus_ystb(mus_ystb),
    .mus_btnstb(mus_btnstb), .mus_rel(mus_rel), .kj_stb(kj_stb),
    .kj_sel(kj_sel), .zah(zah), .kbd_data(kbd_data), .mus_data(mus_data),
    .kj_data(kj_data)
  );

  // ---- reference model: key matrix indexed [row][column] ----
  bit sh[8][NC];
  bit live[8][NC];
  bit stk[8][NC];
  int mx, my, wh, btn;
  int kjm[NJ];

  typedef struct {
    string tag;
    bit ck_k, ck_m, ck_j;
    logic [NC-1:0] k;
    logic [7:0] m;
    logic [NJ*KW-1:0] j;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < NC; c++) begin
        sh[i][c] = 0; live[i][c] = 0; stk[i][c] = 0;
      end
    mx = 0; my = 0; wh = 0; btn = 7;
    for (int n = 0; n < NJ; n++) kjm[n] = 0;
  endfunction

  // Applies the strobes that were present at the clock edge just taken.
  function automatic void model_update();
    int col;
    if (kbd_stb && int'(kbd_in_sel) < NC) begin
      col = NC - 1 - int'(kbd_in_sel);
      for (int i = 0; i < 8; i++) sh[i][col] = kbd_in[i];
    end
    if (kbd_rd)
      for (int i = 0; i < 8; i++)
        if (!zah[i]) for (int c = 0; c < NC; c++) stk[i][c] = 0;
    if (kbd_commit)
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < NC; c++) begin
          live[i][c] = sh[i][c];
          if (sh[i][c]) stk[i][c] = 1;
        end
    if (mus_xstb) mx = mus_rel ? (mx + int'(mus_in)) % 256 : int'(mus_in);
    if (mus_ystb) my = mus_rel ? (my + int'(mus_in)) % 256 : int'(mus_in);
    if (mus_btnstb) begin
      btn = int'(mus_in) % 8;
      wh  = mus_rel ? (wh + int'(mus_in) / 16) % 16 : int'(mus_in) / 16;
    end
    if (kj_stb && int'(kj_sel) < NJ) kjm[kj_sel] = int'(mus_in) % (1 << KW);
  endfunction

  function automatic exp_t model_exp(input string tag);
    exp_t e;
    e.tag = tag; e.ck_k = 1; e.ck_m = 1; e.ck_j = 1;
    for (int c = 0; c < NC; c++) begin
      e.k[c] = 1'b1;
      for (int i = 0; i < 8; i++)
        if (!zah[i] && (live[i][c] || stk[i][c])) e.k[c] = 1'b0;
    end
    if (!zah[0])      e.m = 8'(wh * 16 + 8 + btn);
    else if (!zah[2]) e.m = 8'(mx);
    else              e.m = 8'(my);
    for (int n = 0; n < NJ; n++) e.j[n*KW +: KW] = KW'(kjm[n]);
    return e;
  endfunction

  task automatic sync();
    @(negedge fclk); #1;
  endtask

  task automatic clear_strobes();
    kbd_stb = 0; kbd_commit = 0; kbd_rd = 0;
    mus_xstb = 0; mus_ystb = 0; mus_btnstb = 0; kj_stb = 0;
  endtask

  task automatic tick(input string tag);
    @(posedge fclk); #1;
    model_update();
    clear_strobes();
    q.push_back(model_exp(tag));
    sync();
  endtask

  // Drive zah, queue the model prediction plus optional literal expectations.
  task automatic probe(input logic [7:0] z, input string tag,
                       input bit ck, input logic [NC-1:0] k,
                       input bit cm, input logic [7:0] m,
                       input bit cj, input logic [NJ*KW-1:0] j);
    exp_t e;
    zah = z; #1;
    q.push_back(model_exp(tag));
    if (ck || cm || cj) begin
      e.tag = {tag, "_lit"}; e.ck_k = ck; e.ck_m = cm; e.ck_j = cj;
      e.k = k; e.m = m; e.j = j;
      q.push_back(e);
    end
    sync();
  endtask

  task automatic pulse_reset();
    rst_n = 0; #1;
    model_reset();
    q.push_back(model_exp("rst_pulse"));
    @(negedge fclk); #1;
    rst_n = 1;
  endtask

  // ---- monitor ----
  initial begin
    exp_t e;
    forever begin
      @(negedge fclk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.ck_k) begin
          total++;
          if (kbd_data !== e.k) begin
            bad++;
            $display("FAIL %s kbd_data got=%b want=%b zah=%h", e.tag, kbd_data, e.k, zah);
          end
        end
        if (e.ck_m) begin
          total++;
          if (mus_data !== e.m) begin
            bad++;
            $display("FAIL %s mus_data got=%h want=%h zah=%h", e.tag, mus_data, e.m, zah);
          end
        end
        if (e.ck_j) begin
          total++;
          if (kj_data !== e.j) begin
            bad++;
            $display("FAIL %s kj_data got=%h want=%h", e.tag, kj_data, e.j);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---- stimulus ----
  initial begin
    rst_n = 0; kbd_in = 0; kbd_in_sel = 0; mus_in = 0; mus_rel = 0;
    kj_sel = 0; zah = 8'hFF;
    clear_strobes();
    model_reset();
    sync();
    probe(8'h00, "reset_z00", 1, 5'h1F, 1, 8'h0F, 1, '0);
    probe(8'hFF, "reset_zff", 1, 5'h1F, 1, 8'h00, 0, '0);
    rst_n = 1;

    // single key at byte 0 row 0
    zah = 8'hFF;
    kbd_in = 8'h01; kbd_in_sel = 0; kbd_stb = 1; tick("wr_b0");
    kbd_commit = 1; tick("commit1");
    probe(8'hFE, "key_row0", 1, 5'b01111, 0, '0, 0, '0);
    probe(8'hFD, "key_row1", 1, 5'b11111, 0, '0, 0, '0);

    // sticky hold after release, cleared by a read of row 0
    kbd_in = 8'h00; kbd_in_sel = 0; kbd_stb = 1; kbd_commit = 1; tick("release");
    probe(8'hFE, "sticky_hold", 1, 5'b01111, 0, '0, 0, '0);
    probe(8'hFE, "sticky_hold2", 1, 5'b01111, 0, '0, 0, '0);
    zah = 8'hFE; kbd_rd = 1; tick("rd_clear");
    probe(8'hFE, "sticky_clr", 1, 5'b11111, 0, '0, 0, '0);

    // mouse X relative wrap
    mus_rel = 0; mus_in = 8'hF0; mus_xstb = 1; tick("x_load");
    mus_rel = 1; mus_in = 8'h20; mus_xstb = 1; tick("x_add");
    probe(8'h01, "x_wrap", 0, '0, 1, 8'h10, 0, '0);
    // both axes from one strobe
    mus_rel = 0; mus_in = 8'h5A; mus_xstb = 1; mus_ystb = 1; tick("xy_load");
    probe(8'h01, "xy_x", 0, '0, 1, 8'h5A, 0, '0);
    probe(8'h05, "xy_y", 0, '0, 1, 8'h5A, 0, '0);

    // wheel relative wrap
    mus_rel = 0; mus_in = 8'hF7; mus_btnstb = 1; tick("wh_load");
    mus_rel = 1; mus_in = 8'h35; mus_btnstb = 1; tick("wh_add");
    probe(8'h00, "wheel_wrap", 0, '0, 1, 8'h2D, 0, '0);

    // joystick channels
    mus_in = 8'h15; kj_sel = 0; kj_stb = 1; tick("kj0");
    mus_in = 8'h1A; kj_sel = 1; kj_stb = 1; tick("kj1");
    probe(8'hFF, "kj_both", 0, '0, 0, '0, 1, {5'h1A, 5'h15});
    mus_in = 8'h07; kj_sel = 3; kj_stb = 1; tick("kj_sel3");
    mus_in = 8'h0C; kj_sel = 2; kj_stb = 1; tick("kj_sel2");
    probe(8'hFF, "kj_ignored", 0, '0, 0, '0, 1, {5'h1A, 5'h15});

    // reset between write and commit drops the partial frame
    zah = 8'hFF;
    kbd_in = 8'hFF; kbd_in_sel = 1; kbd_stb = 1; tick("mid_wr");
    pulse_reset();
    kbd_commit = 1; tick("post_rst_commit");
    probe(8'h00, "midrst_z00", 1, 5'h1F, 1, 8'h0F, 1, '0);
    probe(8'hFE, "midrst_zfe", 1, 5'h1F, 0, '0, 0, '0);
    probe(8'h7F, "midrst_z7f", 1, 5'h1F, 0, '0, 0, '0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      kbd_stb    = ($urandom_range(0, 2) == 0);
      kbd_in_sel = 3'($urandom_range(0, 7));
      kbd_in     = 8'($urandom & $urandom);
      kbd_commit = ($urandom_range(0, 3) == 0);
      kbd_rd     = ($urandom_range(0, 4) == 0);
      mus_in     = 8'($urandom);
      mus_rel    = 1'($urandom);
      mus_xstb   = ($urandom_range(0, 3) == 0);
      mus_ystb   = ($urandom_range(0, 3) == 0);
      mus_btnstb = ($urandom_range(0, 3) == 0);
      kj_stb     = ($urandom_range(0, 3) == 0);
      kj_sel     = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       zah = 8'h00;
        1:       zah = ~(8'h01 << $urandom_range(0, 7));
        default: zah = 8'($urandom);
      endcase
      tick("rnd");
      if ($urandom_range(0, 3) == 0)
        probe(8'($urandom), "rnd_probe", 0, '0, 0, '0, 0, '0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end

    sync();
    sync();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain queue_left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
